dbg_access_port: RTL and testbench

- Synthesizable successor to the simulation-only backdoor access logic.
- Accepts 32-bit debug commands over a valid/ready channel and executes them against internal debug registers and external synchronous-read memories.
- Supports multi-lane words (wider than 32 bits) using read-modify-write, and returns a response over a second valid/ready channel.
- Sits between the host debug transport and the instruction/queue memories of the design under test.

---
 rtl/dbg_access_port_if.sv | 25 ++
 rtl/dbg_access_port.sv | 192 +++++++++++++++++++
 tb/tb_dbg_access_port.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_access_port_if.sv
// Command/response handshake bundle for dbg_access_port.
// The host drives the master side; the access port implements the slave side.
interface dbg_access_port_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_opcode;
  logic [31:0] cmd_id;
  logic [31:0] cmd_lane;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_id, cmd_lane, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_id, cmd_lane, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dbg_access_port.sv
// Debug access port: 32-bit commands against internal registers and external sync-read memories.
// Optional command/error counters (opcode 5) enabled by defining DBG_ACCESS_PORT_CMD_CNT_EN.
module dbg_access_port #(
  parameter int unsigned NUM_REG   = 1,
  parameter int unsigned REG_W     = 64,
  parameter int unsigned NUM_MEM   = 4,
  parameter int unsigned MEM_W     = 64,
  parameter int unsigned MEM_AW    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  dbg_access_port_if.slave           bus,
  output logic [NUM_REG*REG_W-1:0]   reg_q,
  output logic [NUM_MEM-1:0]         mem_en,
  output logic [NUM_MEM-1:0]         mem_we,
  output logic [MEM_AW-1:0]          mem_addr,
  output logic [MEM_W-1:0]           mem_wdata,
  input  logic [NUM_MEM*MEM_W-1:0]   mem_rdata
);

  localparam int unsigned REG_LANES = REG_W / 32;
  localparam int unsigned MEM_LANES = MEM_W / 32;

  typedef enum logic [2:0] {IDLE, MRD, MWAIT, MWR, RESP} state_t;

  state_t                     state_q, state_d;
  logic [NUM_REG*REG_W-1:0]   regs_q;
  logic [31:0]                id_q, lane_q, wdata_q;
  logic [MEM_AW-1:0]          addr_q;
  logic                       is_wr_q;
  logic [MEM_W-1:0]           mwdata_q;
  logic [31:0]                rsp_data_q;
  logic                       rsp_err_q;

  logic [31:0]                op;
  logic                       is_reg, is_mem, reg_ok, mem_ok, cmd_err;
  logic [31:0]                reg_rd, acc_data;
  logic [NUM_MEM-1:0]         chan_sel;
  logic [MEM_W-1:0]           cap_word, merged;
  logic [31:0]                cap_lane;
`ifdef DBG_ACCESS_PORT_CMD_CNT_EN
  logic                       is_cnt;
  logic [31:0]                cnt_ok_q, cnt_err_q;
`endif

  always_comb begin
    op      = bus.cmd_opcode;
    is_reg  = (op == 32'd1) || (op == 32'd2);
    is_mem  = (op == 32'd3) || (op == 32'd4);
    reg_ok  = (bus.cmd_id < NUM_REG) && (bus.cmd_lane < REG_LANES);
    mem_ok  = (bus.cmd_id < NUM_MEM) && (bus.cmd_lane < MEM_LANES) && (bus.cmd_addr < MEM_DEPTH);
`ifdef DBG_ACCESS_PORT_CMD_CNT_EN
    is_cnt  = (op == 32'd5);
    cmd_err = (op > 32'd5) || (is_reg && !reg_ok) || (is_mem && !mem_ok) ||
              (is_cnt && (bus.cmd_lane > 32'd1));
`else
    cmd_err = (op > 32'd4) || (is_reg && !reg_ok) || (is_mem && !mem_ok);
`endif
    reg_rd = '0;
    for (int unsigned i = 0; i < NUM_REG; i++)
      for (int unsigned l = 0; l < REG_LANES; l++)
        if (bus.cmd_id == i && bus.cmd_lane == l)
          reg_rd = regs_q[i*REG_W + l*32 +: 32];
    acc_data = '0;
    if (!cmd_err) begin
      if (op == 32'd0)
        acc_data = 32'hdeadbeef;
      else if (op == 32'd2)
        acc_data = reg_rd;
`ifdef DBG_ACCESS_PORT_CMD_CNT_EN
      else if (is_cnt)
        acc_data = (bus.cmd_lane == 32'd0) ? cnt_ok_q : cnt_err_q;
`endif
    end
  end

  always_comb begin
    chan_sel = '0;
    cap_word = '0;
    for (int unsigned c = 0; c < NUM_MEM; c++)
      if (id_q == c) begin
        chan_sel[c] = 1'b1;
        cap_word    = mem_rdata[c*MEM_W +: MEM_W];
      end
    merged   = cap_word;
    cap_lane = '0;
    for (int unsigned l = 0; l < MEM_LANES; l++)
      if (lane_q == l) begin
        cap_lane         = cap_word[l*32 +: 32];
        merged[l*32 +: 32] = wdata_q;
      end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Strobes are masked by reset so a reset landing in MWR never commits the write.
  always_comb begin
    state_d       = state_q;
    mem_en        = '0;
    mem_we        = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = (!cmd_err && is_mem) ? MRD : RESP;
      end
      MRD: begin
        mem_en  = chan_sel;
        state_d = MWAIT;
      end
      MWAIT: state_d = is_wr_q ? MWR : RESP;
      MWR: begin
        mem_en  = chan_sel;
        mem_we  = chan_sel;
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_en        = '0;
      mem_we        = '0;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q     <= '0;
      id_q       <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      mwdata_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cmd_valid) begin
        rsp_err_q  <= cmd_err;
        rsp_data_q <= acc_data;
        if (!cmd_err && op == 32'd1)
          for (int unsigned i = 0; i < NUM_REG; i++)
            for (int unsigned l = 0; l < REG_LANES; l++)
              if (bus.cmd_id == i && bus.cmd_lane == l)
                regs_q[i*REG_W + l*32 +: 32] <= bus.cmd_wdata;
        if (!cmd_err && is_mem) begin
          id_q    <= bus.cmd_id;
          lane_q  <= bus.cmd_lane;
          wdata_q <= bus.cmd_wdata;
          addr_q  <= bus.cmd_addr[MEM_AW-1:0];
          is_wr_q <= (op == 32'd3);
        end
      end
      if (state_q == MWAIT) begin
        if (is_wr_q) mwdata_q   <= merged;
        else         rsp_data_q <= cap_lane;
      end
    end
  end

`ifdef DBG_ACCESS_PORT_CMD_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (state_q == RESP && bus.rsp_ready) begin
      if (rsp_err_q) begin
        if (cnt_err_q != '1) cnt_err_q <= cnt_err_q + 32'd1;
      end else begin
        if (cnt_ok_q != '1) cnt_ok_q <= cnt_ok_q + 32'd1;
      end
    end
  end
`endif

  assign reg_q        = regs_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = mwdata_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_dbg_access_port.sv
// Self-checking bench for dbg_access_port: directed scenarios plus randomized commands
// checked against a word-level reference model of registers, memories and counters.
module tb_dbg_access_port;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dbg_access_port_if bus();

  logic [63:0]  reg_q;
  logic [3:0]   mem_en, mem_we;
  logic [7:0]   mem_addr;
  logic [63:0]  mem_wdata;
  logic [255:0] mem_rdata;

  dbg_access_port #(
    .NUM_REG(1), .REG_W(64), .NUM_MEM(4), .MEM_W(64), .MEM_AW(8), .MEM_DEPTH(256)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .reg_q(reg_q),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External synchronous-read memories
  logic [63:0] mem [4][256];
  logic [63:0] rd  [4];
  logic        mem_clr;
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int c = 0; c < 4; c++)
        for (int a = 0; a < 256; a++) mem[c][a] <= '0;
    end else begin
      for (int c = 0; c < 4; c++)
        if (mem_en[c]) begin
          if (mem_we[c]) mem[c][mem_addr] <= mem_wdata;
          else           rd[c] <= mem[c][mem_addr];
        end
    end
  end
  assign mem_rdata = {rd[3], rd[2], rd[1], rd[0]};

  // Reference model state
  logic [63:0] ref_reg;
  logic [63:0] ref_mem [4][256];
  logic [31:0] ref_ok, ref_errc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observations from the last command
  logic [31:0] obs_data;
  logic        obs_err, obs_rdy, obs_stable;
  int          obs_lat, obs_we_cnt, obs_we_lat;
  logic [63:0] obs_we_data;
  logic [3:0]  obs_we_ch, obs_en;

  task automatic model(input logic [31:0] op, id, lane, addr, wdata,
                       output logic [31:0] d, output logic e, output int lat);
    logic [1:0]  ci;
    logic [7:0]  ai;
    logic [63:0] mask;
    ci = id[1:0];
    ai = addr[7:0];
    mask = 64'hffffffff << (32 * lane);
    e = 1'b0; d = '0; lat = 1;
    case (op)
      32'd0: d = 32'hdeadbeef;
      32'd1, 32'd2: begin
        if (id >= 1 || lane >= 2) e = 1'b1;
        else if (op == 32'd1) ref_reg = (ref_reg & ~mask) | (64'(wdata) << (32 * lane));
        else d = 32'(ref_reg >> (32 * lane));
      end
      32'd3, 32'd4: begin
        if (id >= 4 || lane >= 2 || addr >= 256) e = 1'b1;
        else if (op == 32'd4) begin
          d = 32'(ref_mem[ci][ai] >> (32 * lane));
          lat = 3;
        end else begin
          ref_mem[ci][ai] = (ref_mem[ci][ai] & ~mask) | (64'(wdata) << (32 * lane));
          lat = 4;
        end
      end
`ifdef DBG_ACCESS_PORT_CMD_CNT_EN
      32'd5: begin
        if (lane == 0)      d = ref_ok;
        else if (lane == 1) d = ref_errc;
        else                e = 1'b1;
      end
`endif
      default: e = 1'b1;
    endcase
    if (e) begin
      d = '0;
      lat = 1;
      if (ref_errc != 32'hffffffff) ref_errc = ref_errc + 1;
    end else if (ref_ok != 32'hffffffff) ref_ok = ref_ok + 1;
  endtask

  task automatic do_cmd(input logic [31:0] op, id, lane, addr, wdata, input int hold);
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_id = id;
    bus.cmd_lane = lane; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.rsp_ready = (hold == 0);
    obs_rdy = bus.cmd_ready;
    obs_en = '0; obs_we_cnt = 0; obs_we_lat = -1; obs_we_data = '0; obs_we_ch = '0;
    obs_lat = 0; obs_stable = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) bus.cmd_valid = 1'b0;
      obs_en = obs_en | mem_en;
      if (|mem_we) begin
        obs_we_cnt++; obs_we_lat = k; obs_we_data = mem_wdata; obs_we_ch = mem_we;
      end
      if (bus.rsp_valid) begin
        obs_lat = k;
        break;
      end
    end
    obs_data = bus.rsp_data;
    obs_err  = bus.rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== obs_data || bus.rsp_err !== obs_err)
        obs_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b want 0", bus.cmd_ready); end
    n_cmp++; if (mem_en !== 4'b0) begin n_fail++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    reset = 1'b0; mem_clr = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h0)
      begin n_fail++; $display("FAIL post_rst_rsp got v=%b e=%b d=%h want 0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    n_cmp++; if (reg_q !== 64'h0) begin n_fail++; $display("FAIL post_rst_reg_q got %h want 0", reg_q); end
    n_cmp++; if (mem_en !== 4'b0 || mem_we !== 4'b0 || mem_addr !== 8'h0 || mem_wdata !== 64'h0)
      begin n_fail++; $display("FAIL post_rst_mem got en=%b we=%b a=%h wd=%h want 0", mem_en, mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_nop();
    logic [31:0] d; logic e; int lat;
    model(0, 0, 0, 0, 0, d, e, lat);
    do_cmd(0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_lat !== 1) begin n_fail++; $display("FAIL nop_lat got %0d want 1", obs_lat); end
    n_cmp++; if (obs_data !== 32'hdeadbeef || obs_err !== 1'b0)
      begin n_fail++; $display("FAIL nop_rsp got d=%h e=%b want deadbeef/0", obs_data, obs_err); end
    n_cmp++; if (obs_en !== 4'b0) begin n_fail++; $display("FAIL nop_mem_en got %b want 0", obs_en); end
  endtask

  task automatic test_reg();
    logic [31:0] d; logic e; int lat;
    model(1, 0, 1, 0, 32'h12345678, d, e, lat);
    do_cmd(1, 0, 1, 0, 32'h12345678, 0);
    n_cmp++; if (obs_err !== 1'b0 || obs_data !== 32'h0 || obs_lat !== 1)
      begin n_fail++; $display("FAIL reg_wr got d=%h e=%b lat=%0d want 0/0/1", obs_data, obs_err, obs_lat); end
    model(2, 0, 1, 0, 0, d, e, lat);
    do_cmd(2, 0, 1, 0, 0, 0);
    n_cmp++; if (obs_data !== 32'h12345678 || obs_err !== 1'b0)
      begin n_fail++; $display("FAIL reg_rd_l1 got %h want 12345678", obs_data); end
    model(2, 0, 0, 0, 0, d, e, lat);
    do_cmd(2, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_data !== 32'h0 || obs_err !== 1'b0)
      begin n_fail++; $display("FAIL reg_rd_l0 got %h want 0", obs_data); end
    n_cmp++; if (reg_q !== 64'h12345678_00000000)
      begin n_fail++; $display("FAIL reg_q got %h want 1234567800000000", reg_q); end
  endtask

  task automatic test_mem();
    logic [31:0] d; logic e; int lat;
    model(3, 2, 0, 5, 32'hBBBBBBBB, d, e, lat); do_cmd(3, 2, 0, 5, 32'hBBBBBBBB, 0);
    model(3, 2, 1, 5, 32'hAAAAAAAA, d, e, lat); do_cmd(3, 2, 1, 5, 32'hAAAAAAAA, 0);
    n_cmp++; if (obs_we_data !== 64'hAAAAAAAA_BBBBBBBB)
      begin n_fail++; $display("FAIL mem_preload got %h want aaaaaaaabbbbbbbb", obs_we_data); end
    model(3, 2, 0, 5, 32'h0, d, e, lat); do_cmd(3, 2, 0, 5, 32'h0, 0);
    n_cmp++; if (obs_we_cnt !== 1 || obs_we_lat !== 3 || obs_we_ch !== 4'b0100)
      begin n_fail++; $display("FAIL mem_wr_pulse got cnt=%0d at=%0d ch=%b want 1/3/0100", obs_we_cnt, obs_we_lat, obs_we_ch); end
    n_cmp++; if (obs_we_data !== 64'hAAAAAAAA_00000000)
      begin n_fail++; $display("FAIL mem_wr_data got %h want aaaaaaaa00000000", obs_we_data); end
    n_cmp++; if (obs_lat !== 4 || obs_err !== 1'b0 || obs_data !== 32'h0)
      begin n_fail++; $display("FAIL mem_wr_rsp got lat=%0d e=%b d=%h want 4/0/0", obs_lat, obs_err, obs_data); end
    model(4, 2, 1, 5, 0, d, e, lat); do_cmd(4, 2, 1, 5, 0, 0);
    n_cmp++; if (obs_data !== 32'hAAAAAAAA || obs_lat !== 3 || obs_we_cnt !== 0)
      begin n_fail++; $display("FAIL mem_rd got d=%h lat=%0d we=%0d want aaaaaaaa/3/0", obs_data, obs_lat, obs_we_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat; logic seen;
    model(2, 0, 1, 0, 0, d, e, lat);
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 2; bus.cmd_id = 0; bus.cmd_lane = 1;
    bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.rsp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.cmd_valid = 1'b1; bus.cmd_opcode = 0;
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d)
        begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h want 1/%h", k, bus.rsp_valid, bus.rsp_data, d); end
      n_cmp++; if (bus.cmd_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_cmd_ready[%0d] got %b want 0", k, bus.cmd_ready); end
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", bus.rsp_valid, bus.cmd_ready); end
    seen = 1'b0;
    repeat (3) begin @(negedge clock); seen = seen | bus.rsp_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_stray_rsp got %b want 0", seen); end
  endtask

  task automatic test_errors();
    logic [31:0] ops [7] = '{32'd4, 32'd3, 32'd4, 32'd7, 32'd2, 32'd1, 32'd5};
    logic [31:0] ids [7] = '{32'd4, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
    logic [31:0] lns [7] = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0};
    logic [31:0] ads [7] = '{32'd0, 32'd0, 32'd256, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] d; logic e; int lat;
    for (int i = 0; i < 7; i++) begin
      model(ops[i], ids[i], lns[i], ads[i], 32'h5a5a5a5a, d, e, lat);
      do_cmd(ops[i], ids[i], lns[i], ads[i], 32'h5a5a5a5a, 0);
      n_cmp++; if (obs_err !== e || obs_data !== d || obs_lat !== lat)
        begin n_fail++; $display("FAIL err_case[%0d] got e=%b d=%h lat=%0d want %b/%h/%0d", i, obs_err, obs_data, obs_lat, e, d, lat); end
      n_cmp++; if (e && obs_en !== 4'b0) begin n_fail++; $display("FAIL err_mem_en[%0d] got %b want 0", i, obs_en); end
      n_cmp++; if (reg_q !== ref_reg) begin n_fail++; $display("FAIL err_reg_q[%0d] got %h want %h", i, reg_q, ref_reg); end
    end
  endtask

  task automatic test_random();
    logic [31:0] op, id, lane, addr, wdata, d; logic e; int lat, hold, r;
    logic [31:0] addr_tab [6] = '{32'd0, 32'd1, 32'd2, 32'd255, 32'd256, 32'hffff0001};
    for (int n = 0; n < 250; n++) begin
      r     = int'($urandom_range(0, 11));
      op    = (r > 7) ? ((r > 9) ? 32'd3 : 32'd4) : 32'(r);
      id    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 5)) :
              ((op < 3) ? 32'd0 : 32'($urandom_range(0, 3)));
      lane  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(2, 40)) : 32'($urandom_range(0, 1));
      addr  = addr_tab[$urandom_range(0, 5)];
      wdata = $urandom;
      hold  = int'($urandom_range(0, 2));
      model(op, id, lane, addr, wdata, d, e, lat);
      do_cmd(op, id, lane, addr, wdata, hold);
      n_cmp++; if (obs_rdy !== 1'b1 || obs_data !== d || obs_err !== e || obs_lat !== lat || obs_stable !== 1'b1)
        begin n_fail++; $display("FAIL rand[%0d] op=%0d id=%0d ln=%0d a=%h got rdy=%b d=%h e=%b lat=%0d st=%b want 1/%h/%b/%0d/1",
          n, op, id, lane, addr, obs_rdy, obs_data, obs_err, obs_lat, obs_stable, d, e, lat); end
      n_cmp++; if (reg_q !== ref_reg) begin n_fail++; $display("FAIL rand_reg_q[%0d] got %h want %h", n, reg_q, ref_reg); end
      if (op == 32'd3 && !e) begin
        n_cmp++; if (obs_we_cnt !== 1 || obs_we_data !== ref_mem[id[1:0]][addr[7:0]])
          begin n_fail++; $display("FAIL rand_we[%0d] got cnt=%0d wd=%h want 1/%h", n, obs_we_cnt, obs_we_data, ref_mem[id[1:0]][addr[7:0]]); end
      end else begin
        n_cmp++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL rand_no_we[%0d] got %0d want 0", n, obs_we_cnt); end
      end
    end
  endtask

  task automatic test_reset_mwr();
    logic [31:0] d; logic e; int lat; logic [3:0] act; logic v;
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 3; bus.cmd_id = 1; bus.cmd_lane = 1;
    bus.cmd_addr = 7; bus.cmd_wdata = 32'hC0FFEE11; bus.rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 4'b0 || mem_en !== 4'b0)
      begin n_fail++; $display("FAIL rst_mwr_strobe got en=%b we=%b want 0/0", mem_en, mem_we); end
    act = '0; v = 1'b0;
    repeat (3) begin @(negedge clock); act = act | mem_en | mem_we; v = v | bus.rsp_valid; end
    reset = 1'b0;
    ref_reg = '0; ref_ok = '0; ref_errc = '0;
    repeat (2) begin @(negedge clock); act = act | mem_en | mem_we; v = v | bus.rsp_valid; end
    n_cmp++; if (act !== 4'b0) begin n_fail++; $display("FAIL rst_mwr_mem_activity got %b want 0", act); end
    n_cmp++; if (v !== 1'b0) begin n_fail++; $display("FAIL rst_mwr_rsp_valid got %b want 0", v); end
    n_cmp++; if (reg_q !== 64'h0) begin n_fail++; $display("FAIL rst_mwr_reg_q got %h want 0", reg_q); end
    n_cmp++; if (mem[1][7] !== ref_mem[1][7])
      begin n_fail++; $display("FAIL rst_mwr_mem_word got %h want %h", mem[1][7], ref_mem[1][7]); end
    model(4, 1, 1, 7, 0, d, e, lat); do_cmd(4, 1, 1, 7, 0, 0);
    n_cmp++; if (obs_data !== d || obs_err !== e)
      begin n_fail++; $display("FAIL rst_mwr_readback got %h/%b want %h/%b", obs_data, obs_err, d, e); end
    model(5, 0, 0, 0, 0, d, e, lat); do_cmd(5, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_data !== d || obs_err !== e || obs_lat !== lat)
      begin n_fail++; $display("FAIL rst_mwr_cnt got d=%h e=%b lat=%0d want %h/%b/%0d", obs_data, obs_err, obs_lat, d, e, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      model(32'(i & 1) * 2, 0, 32'(i >> 1), 0, 0, d, e, lat);
      do_cmd(32'(i & 1) * 2, 0, 32'(i >> 1), 0, 0, 0);
      n_cmp++; if (obs_rdy !== 1'b1 || obs_lat !== 1 || obs_data !== d)
        begin n_fail++; $display("FAIL b2b[%0d] got rdy=%b lat=%0d d=%h want 1/1/%h", i, obs_rdy, obs_lat, obs_data, d); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_id = '0; bus.cmd_lane = '0;
    bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b1;
    ref_reg = '0; ref_ok = '0; ref_errc = '0;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 256; a++) ref_mem[c][a] = '0;
    test_reset();
    test_nop();
    test_reg();
    test_mem();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
